// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM-stage data port (master) and the
// data memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_load_mode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_load_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_load_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: one sized load/store at a time, fixed wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN flags/drops misaligned and out-of-range accesses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_responder_if.slave   io_mem
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] M_WORD  = 2'b00;
  localparam logic [1:0] M_HALF  = 2'b01;
  localparam logic [1:0] M_BYTES = 2'b10;

  function automatic logic f_misaligned(input logic [1:0] lo, input logic [1:0] mode);
    case (mode)
      M_WORD:  return (lo != 2'b00);
      M_HALF:  return lo[0];
      default: return 1'b0;
    endcase
  endfunction

  // Force-aligned byte lane of the access; identical to lo for aligned addresses.
  function automatic logic [1:0] f_lane(input logic [1:0] lo, input logic [1:0] mode);
    case (mode)
      M_WORD:  return 2'b00;
      M_HALF:  return {lo[1], 1'b0};
      default: return lo;
    endcase
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] lane, input logic [1:0] mode);
    case (mode)
      M_WORD:  return 4'b1111;
      M_HALF:  return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << lane;
    endcase
  endfunction

  function automatic logic [31:0] f_wlanes(input logic [31:0] wdata, input logic [1:0] mode);
    case (mode)
      M_WORD:  return wdata;
      M_HALF:  return {2{wdata[15:0]}};
      default: return {4{wdata[7:0]}};
    endcase
  endfunction

  function automatic logic [31:0] f_size(input logic [31:0] word, input logic [1:0] lane,
                                         input logic [1:0] mode);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half   = lane[1] ? word[31:16] : word[15:0];
    byte_v = word[8*lane +: 8];
    case (mode)
      M_WORD:  return word;
      M_HALF:  return {{16{half[15]}}, half};
      M_BYTES: return {{24{byte_v[7]}}, byte_v};
      default: return {24'h0, byte_v};
    endcase
  endfunction

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_mode;
  logic        r_rd_valid;
  logic        r_err;

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_acc_write;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [1:0]  w_acc_mode;
  logic [1:0]  w_acc_lane;
  logic        w_acc_oor;
  logic        w_acc_drop;
  logic        w_acc_err;
  logic        w_ram_we;
  logic        w_ram_re;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_be;
  logic [31:0] w_wlanes;
  logic [31:0] w_rd_word;
  logic [1:0]  w_rsp_lane;

  assign w_accept = (r_state == S_IDLE) && io_mem.req_valid;

  // With zero wait states the RAM is accessed on the accepting edge itself,
  // so the access fields come straight from the bus in that case.
  assign w_enter_resp = ((r_state == S_IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));

  assign w_acc_write = (r_state == S_IDLE) ? io_mem.req_write     : r_write;
  assign w_acc_addr  = (r_state == S_IDLE) ? io_mem.req_addr      : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? io_mem.req_wdata     : r_wdata;
  assign w_acc_mode  = (r_state == S_IDLE) ? io_mem.req_load_mode : r_mode;

  assign w_acc_lane = f_lane(w_acc_addr[1:0], w_acc_mode);
  assign w_acc_oor  = (w_acc_addr >= BYTE_LIMIT);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_acc_drop = w_acc_oor || f_misaligned(w_acc_addr[1:0], w_acc_mode);
  assign w_acc_err  = w_acc_drop;
`else
  assign w_acc_drop = w_acc_oor;
  assign w_acc_err  = 1'b0;
`endif

  assign w_ram_we = w_enter_resp &&  w_acc_write && !w_acc_drop;
  assign w_ram_re = w_enter_resp && !w_acc_write && !w_acc_drop;
  assign w_idx    = w_acc_addr[AW+1:2];
  assign w_be     = f_be(w_acc_lane, w_acc_mode);
  assign w_wlanes = f_wlanes(w_acc_wdata, w_acc_mode);

  // One byte-wide RAM per lane keeps byte-enable writes a plain array write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rd_lane;

      always_ff @(posedge clk) begin
        if (w_ram_we && w_be[gi]) begin
          r_mem[w_idx] <= w_wlanes[8*gi +: 8];
        end
        if (w_ram_re) begin
          r_rd_lane <= r_mem[w_idx];
        end
      end

      assign w_rd_word[8*gi +: 8] = r_rd_lane;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_mode     <= 2'b00;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= io_mem.req_write;
            r_addr  <= io_mem.req_addr;
            r_wdata <= io_mem.req_wdata;
            r_mode  <= io_mem.req_load_mode;
            r_cnt   <= WAIT_INIT;
            r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (io_mem.rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_resp) begin
        r_rd_valid <= w_ram_re;
        r_err      <= w_acc_err;
      end
    end
  end

  assign w_rsp_lane = f_lane(r_addr[1:0], r_mode);

  // Outputs derive only from registers, so they are zero outside RESP.
  assign io_mem.req_ready = (r_state == S_IDLE);
  assign io_mem.rsp_valid = (r_state == S_RESP);
  assign io_mem.rsp_rdata = ((r_state == S_RESP) && r_rd_valid) ?
                            f_size(w_rd_word, w_rsp_lane, r_mode) : 32'd0;
  assign io_mem.rsp_err   = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (WAIT_CYCLES=2, DEPTH_WORDS=256).
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_mem (bus)
  );

  always #5 clk = ~clk;

  // Drives one full transaction; expiry of either bounded wait is a failure.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] mode, output logic [31:0] rdata, output logic err,
                        output int lat);
    int guard;
    rdata = 32'hx;
    err = 1'bx;
    lat = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_load_mode = mode;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (guard >= 50) begin
      n_fail++;
      $display("[TB] FAIL req_accept_timeout: req_ready stuck at %b, required 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_tests++;
    if (bus.rsp_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rsp_timeout: rsp_valid=%b after %0d edges, required 1", bus.rsp_valid, lat);
      lat = 0;
      return;
    end
    rdata = bus.rsp_rdata;
    err = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    $display("[TB] %s addr=%h wdata=%h mode=%0d -> rdata=%h err=%b lat=%0d",
             wr ? "ST" : "LD", addr, wdata, mode, rdata, err, lat);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_tests++;
    if (bus.rsp_rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    n_tests++;
    if (bus.rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b00, rd, er, lat);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("[TB] FAIL st_latency: got %0d want 3", lat); end
    n_tests++;
    if (rd !== 32'd0) begin n_fail++; $display("[TB] FAIL st_rdata_zero: got %h want 0", rd); end
    do_req(1'b0, 32'h10, 32'h0, 2'b00, rd, er, lat);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("[TB] FAIL ld_latency: got %0d want 3", lat); end
    n_tests++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL ld_word: got %h want deadbeef", rd); end
  endtask

  task automatic test_sizing();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h13, 32'h0, 2'b10, rd, er, lat);
    n_tests++;
    if (rd !== 32'hFFFFFFDE) begin n_fail++; $display("[TB] FAIL ld_byte_signed: got %h want ffffffde", rd); end
    do_req(1'b0, 32'h13, 32'h0, 2'b11, rd, er, lat);
    n_tests++;
    if (rd !== 32'h000000DE) begin n_fail++; $display("[TB] FAIL ld_byte_unsigned: got %h want 000000de", rd); end
    do_req(1'b0, 32'h12, 32'h0, 2'b01, rd, er, lat);
    n_tests++;
    if (rd !== 32'hFFFFDEAD) begin n_fail++; $display("[TB] FAIL ld_half_signed: got %h want ffffdead", rd); end
    do_req(1'b0, 32'h10, 32'h0, 2'b01, rd, er, lat);
    n_tests++;
    if (rd !== 32'hFFFFBEEF) begin n_fail++; $display("[TB] FAIL ld_half_low: got %h want ffffbeef", rd); end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h11, 32'h00000055, 2'b10, rd, er, lat);
    do_req(1'b0, 32'h10, 32'h0, 2'b00, rd, er, lat);
    n_tests++;
    if (rd !== 32'hDEAD55EF) begin n_fail++; $display("[TB] FAIL st_byte_merge: got %h want dead55ef", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int guard;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10; bus.req_load_mode = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    guard = 0;
    while (bus.rsp_valid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_rsp_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
      n_tests++;
      if (bus.rsp_rdata !== 32'hDEAD55EF) begin n_fail++; $display("[TB] FAIL hold_rsp_rdata[%0d]: got %h want dead55ef", i, bus.rsp_rdata); end
      n_tests++;
      if (bus.req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
      bus.req_valid = (i == 1);
      bus.req_write = 1'b1; bus.req_wdata = 32'h0; bus.req_addr = 32'h10; bus.req_load_mode = 2'b00;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL release_state: rsp_valid=%b req_ready=%b want 0/1", bus.rsp_valid, bus.req_ready);
    end
    $display("[TB] LD addr=00000010 held 5 cycles, pulse ignored");
    do_req(1'b0, 32'h10, 32'h0, 2'b00, rd, er, lat);
    n_tests++;
    if (rd !== 32'hDEAD55EF) begin n_fail++; $display("[TB] FAIL ignored_pulse: got %h want dead55ef", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h12, 32'h0, 2'b00, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    n_tests++;
    if (er !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_word_err: got %b want 1", er); end
    n_tests++;
    if (rd !== 32'd0) begin n_fail++; $display("[TB] FAIL mis_word_rdata: got %h want 0", rd); end
`else
    n_tests++;
    if (er !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_word_err: got %b want 0", er); end
    n_tests++;
    if (rd !== 32'hDEAD55EF) begin n_fail++; $display("[TB] FAIL mis_word_rdata: got %h want dead55ef", rd); end
    do_req(1'b0, 32'h13, 32'h0, 2'b01, rd, er, lat);
    n_tests++;
    if (rd !== 32'hFFFFDEAD) begin n_fail++; $display("[TB] FAIL mis_half_rdata: got %h want ffffdead", rd); end
`endif
  endtask

  task automatic test_range_and_half();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h0, 32'hA5A5A5A5, 2'b00, rd, er, lat);
    do_req(1'b1, 32'h400, 32'h11111111, 2'b00, rd, er, lat);
    do_req(1'b0, 32'h0, 32'h0, 2'b00, rd, er, lat);
    n_tests++;
    if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("[TB] FAIL oor_store_dropped: got %h want a5a5a5a5", rd); end
    do_req(1'b0, 32'h400, 32'h0, 2'b00, rd, er, lat);
    n_tests++;
    if (rd !== 32'd0) begin n_fail++; $display("[TB] FAIL oor_load_zero: got %h want 0", rd); end
    do_req(1'b1, 32'h3FC, 32'h9A00_0000, 2'b00, rd, er, lat);
    do_req(1'b0, 32'h3FF, 32'h0, 2'b11, rd, er, lat);
    n_tests++;
    if (rd !== 32'h0000009A) begin n_fail++; $display("[TB] FAIL last_byte: got %h want 0000009a", rd); end
    do_req(1'b1, 32'h20, 32'hCAFE0000, 2'b00, rd, er, lat);
    do_req(1'b1, 32'h22, 32'h0000BEEF, 2'b01, rd, er, lat);
    do_req(1'b0, 32'h20, 32'h0, 2'b00, rd, er, lat);
    n_tests++;
    if (rd !== 32'hBEEF0000) begin n_fail++; $display("[TB] FAIL st_half_upper: got %h want beef0000", rd); end
    do_req(1'b1, 32'h20, 32'h00000080, 2'b10, rd, er, lat);
    do_req(1'b0, 32'h20, 32'h0, 2'b10, rd, er, lat);
    n_tests++;
    if (rd !== 32'hFFFFFF80) begin n_fail++; $display("[TB] FAIL st_byte_lane0: got %h want ffffff80", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; int guard;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0; bus.req_load_mode = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    guard = 0;
    while (bus.rsp_valid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    n_tests++;
    if (bus.rsp_rdata !== 32'hA5A5A5A5) begin n_fail++; $display("[TB] FAIL b2b_rdata: got %h want a5a5a5a5", bus.rsp_rdata); end
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_one_cycle: rsp_valid=%b req_ready=%b want 0/1", bus.rsp_valid, bus.req_ready);
    end
    bus.rsp_ready = 1'b0;
    $display("[TB] LD addr=00000000 with rsp_ready held high");
    do_req(1'b0, 32'h10, 32'h0, 2'b00, rd, er, lat);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d want 3", lat); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h20, 32'hCAFE0000, 2'b00, rd, er, lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h00001234; bus.req_load_mode = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_req_ready: got %b want 1", bus.req_ready); end
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_rsp_valid: got %b want 0", bus.rsp_valid); end
    $display("[TB] ST addr=00000020 wdata=00001234 aborted by reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 32'h20, 32'h0, 2'b00, rd, er, lat);
    n_tests++;
    if (rd !== 32'hCAFE0000) begin n_fail++; $display("[TB] FAIL rst_mid_ram: got %h want cafe0000", rd); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_load_mode = 2'b00;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_word();
    test_sizing();
    test_byte_store();
    test_backpressure();
    test_misalign();
    test_range_and_half();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
